func_call_port: RTL and testbench

//  Parent-side adapter between one HLS parent core and one parent slot of func_arbiter.

---
 rtl/func_arbiter_pkg.sv | 28 ++
 rtl/func_call_credit.sv | 44 ++++
 rtl/func_call_port.sv | 118 +++++++++++
 tb/tb_func_call_port.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/func_arbiter_pkg.sv
// Shared definitions for the function-call arbiter slice.
// Holds the argument/return widths used by every parent and child adapter,
// plus the packed layouts of the command word (parent -> arbiter) and the
// return word (arbiter -> parent). Field order in the packed structs runs
// MSB first, so the args field lands in the least significant bits.
package func_arbiter_pkg;

  localparam int ARG_W     = 32;
  localparam int ARG_NUM   = 4;
  localparam int RET_DW    = 32;
  localparam int CHILD_NUM = 64;
  localparam int CHILD_LOG = (CHILD_NUM == 1) ? 1 : $clog2(CHILD_NUM);
  localparam int CMD_DW    = ARG_W*ARG_NUM + CHILD_LOG + 1 + 32;
  localparam int RET_WORD_DW = RET_DW + CHILD_LOG;

  typedef struct packed {
    logic [31:0]              pc;
    logic                     ret_req;
    logic [CHILD_LOG-1:0]     child;
    logic [ARG_NUM*ARG_W-1:0] args;
  } cmd_word_t;

  typedef struct packed {
    logic [CHILD_LOG-1:0] child;
    logic [RET_DW-1:0]    data;
  } ret_word_t;

endpackage

// File: rtl/func_call_credit.sv
// Credit counter bounding outstanding return-expecting calls.
// Ports:
//   clk, rstn  clock, async active-low reset
//   inc        a return-expecting call was accepted this cycle
//   dec        a return value was handed to the parent this cycle
//   count      current number of outstanding calls
//   at_limit   count has reached MAX_OUT; new return-expecting calls must stall
//   err        sticky: a return was delivered while nothing was outstanding
module func_call_credit #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = $clog2(MAX_OUT+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_limit,
  output logic             err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUT);

  // A simultaneous inc/dec cancels out. A dec with no credit in use is a
  // protocol error: flag it and hold the counter at zero instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (dec && (count == '0)) begin
        err <= 1'b1;
      end
      if (inc && !dec) begin
        count <= count + 1'b1;
      end else if (dec && !inc && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  assign at_limit = (count >= LIMIT);

endmodule

// File: rtl/func_call_port.sv
// Parent-side adapter between one HLS parent core and one parent slot of
// func_arbiter.
// Ports:
//   clk, rstn           clock, async active-low reset
//   call_*              call request from the parent (valid/ready)
//   cmd_din_o/write_o   command-FIFO write side towards the arbiter
//   cmd_full_n_i        arbiter command FIFO has room
//   ret_empty_n_i       per-parent return FIFO holds a word (FWFT)
//   ret_fifo_i          head of the return FIFO, {child, data}
//   ret_pop_o           pops the return FIFO head
//   ret_vld_o/rdy_i     return value towards the parent (valid/ready)
//   ret_child_o/data_o  source child and value of the presented return
//   outstanding_o       return-expecting calls not yet answered
//   busy_o              anything in flight
//   err_o               sticky: return arrived with no outstanding call
module func_call_port
  import func_arbiter_pkg::*;
#(
  parameter int CHILD       = 64,
  parameter int LOG_CHILD   = (CHILD == 1) ? 1 : $clog2(CHILD),
  parameter int MAX_OUT     = 8,
  parameter int CMD_FIFO_DW = ARG_W*ARG_NUM + LOG_CHILD + 1 + 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         call_vld_i,
  output logic                         call_rdy_o,
  input  logic [LOG_CHILD-1:0]         call_child_i,
  input  logic                         call_ret_i,
  input  logic [31:0]                  call_pc_i,
  input  logic [ARG_NUM*ARG_W-1:0]     call_args_i,
  output logic [CMD_FIFO_DW-1:0]       cmd_din_o,
  output logic                         cmd_write_o,
  input  logic                         cmd_full_n_i,
  input  logic                         ret_empty_n_i,
  input  logic [RET_DW+LOG_CHILD-1:0]  ret_fifo_i,
  output logic                         ret_pop_o,
  output logic                         ret_vld_o,
  input  logic                         ret_rdy_i,
  output logic [LOG_CHILD-1:0]         ret_child_o,
  output logic [RET_DW-1:0]            ret_data_o,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int OUT_W = $clog2(MAX_OUT+1);

  cmd_word_t  cmd_r;
  logic       cmd_vld_r;
  ret_word_t  ret_r;
  logic       ret_vld_r;

  logic             call_acc;
  logic             ret_hs;
  logic             credit_full;
  logic [OUT_W-1:0] credit_cnt;
  logic             credit_err;

  // The command register frees up in the same cycle it is written, so the
  // parent sees ready combinationally and can issue one call per cycle.
  assign cmd_write_o = cmd_vld_r & cmd_full_n_i;
  assign call_rdy_o  = (!cmd_vld_r | cmd_write_o) & (!call_ret_i | !credit_full);
  assign call_acc    = call_vld_i & call_rdy_o;
  assign cmd_din_o   = cmd_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_r     <= '0;
      cmd_vld_r <= 1'b0;
    end else if (call_acc) begin
      cmd_r     <= '{pc: call_pc_i, ret_req: call_ret_i,
                     child: call_child_i, args: call_args_i};
      cmd_vld_r <= 1'b1;
    end else if (cmd_write_o) begin
      cmd_vld_r <= 1'b0;
    end
  end

  // Return skid: pop a new word whenever the held one is empty or being
  // taken, which keeps one return per cycle flowing while ret_rdy_i is high.
  assign ret_pop_o = ret_empty_n_i & (!ret_vld_r | ret_rdy_i);
  assign ret_hs    = ret_vld_r & ret_rdy_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ret_r     <= '0;
      ret_vld_r <= 1'b0;
    end else if (ret_pop_o) begin
      ret_r     <= ret_word_t'(ret_fifo_i);
      ret_vld_r <= 1'b1;
    end else if (ret_rdy_i) begin
      ret_vld_r <= 1'b0;
    end
  end

  assign ret_vld_o   = ret_vld_r;
  assign ret_child_o = ret_r.child;
  assign ret_data_o  = ret_r.data;

  func_call_credit #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (OUT_W)
  ) u_credit (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (call_acc & call_ret_i),
    .dec      (ret_hs),
    .count    (credit_cnt),
    .at_limit (credit_full),
    .err      (credit_err)
  );

  assign outstanding_o = credit_cnt;
  assign err_o         = credit_err;
  assign busy_o        = cmd_vld_r | (credit_cnt != '0) | ret_vld_r;

endmodule

// File: tb/tb_func_call_port.sv
// Self-checking bench for func_call_port (instantiated with MAX_OUT=2).
// A behavioural model built from queues (pending command, held return,
// return FIFO contents) and an integer credit count predicts every output
// each cycle; scenario tasks add targeted checks.
module tb_func_call_port;
  import func_arbiter_pkg::*;

  localparam int MAX_OUT = 2;
  localparam int OUT_W   = $clog2(MAX_OUT+1);
  localparam int LC      = 6;
  localparam int CDW     = ARG_W*ARG_NUM + LC + 1 + 32;

  logic                    clk;
  logic                    rstn;
  logic                    call_vld_i;
  logic                    call_rdy_o;
  logic [LC-1:0]           call_child_i;
  logic                    call_ret_i;
  logic [31:0]             call_pc_i;
  logic [ARG_NUM*ARG_W-1:0] call_args_i;
  logic [CDW-1:0]          cmd_din_o;
  logic                    cmd_write_o;
  logic                    cmd_full_n_i;
  logic                    ret_empty_n_i;
  logic [RET_DW+LC-1:0]    ret_fifo_i;
  logic                    ret_pop_o;
  logic                    ret_vld_o;
  logic                    ret_rdy_i;
  logic [LC-1:0]           ret_child_o;
  logic [RET_DW-1:0]       ret_data_o;
  logic [OUT_W-1:0]        outstanding_o;
  logic                    busy_o;
  logic                    err_o;

  func_call_port #(.CHILD(64), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rstn(rstn),
    .call_vld_i(call_vld_i), .call_rdy_o(call_rdy_o), .call_child_i(call_child_i),
    .call_ret_i(call_ret_i), .call_pc_i(call_pc_i), .call_args_i(call_args_i),
    .cmd_din_o(cmd_din_o), .cmd_write_o(cmd_write_o), .cmd_full_n_i(cmd_full_n_i),
    .ret_empty_n_i(ret_empty_n_i), .ret_fifo_i(ret_fifo_i), .ret_pop_o(ret_pop_o),
    .ret_vld_o(ret_vld_o), .ret_rdy_i(ret_rdy_i), .ret_child_o(ret_child_o),
    .ret_data_o(ret_data_o), .outstanding_o(outstanding_o), .busy_o(busy_o),
    .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [CDW-1:0]       pend[$];
  logic [RET_DW+LC-1:0] hold[$];
  logic [RET_DW+LC-1:0] ret_src[$];
  int  m_out = 0;
  bit  m_err = 0;
  int  m_acc_ret = 0;
  int  wr_count = 0;
  int  pop_count = 0;
  bit  e_write, e_rdy, e_acc, e_hs, e_pop;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // per-cycle prediction and comparison, away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      e_write = (pend.size() != 0) && cmd_full_n_i;
      e_rdy   = ((pend.size() == 0) || cmd_full_n_i) && (!call_ret_i || (m_out < MAX_OUT));
      e_acc   = call_vld_i && e_rdy;
      e_hs    = (hold.size() != 0) && ret_rdy_i;
      e_pop   = ret_empty_n_i && ((hold.size() == 0) || ret_rdy_i);
      if (cmd_write_o) wr_count++;
      if (ret_pop_o) pop_count++;
      checks++;
      if (cmd_write_o !== e_write) begin
        errors++; $display("[TB] FAIL cmd_write: got %b want %b at %0t", cmd_write_o, e_write, $time);
      end
      if (pend.size() != 0) begin
        checks++;
        if (cmd_din_o !== pend[0]) begin
          errors++; $display("[TB] FAIL cmd_din: got %h want %h at %0t", cmd_din_o, pend[0], $time);
        end
      end
      checks++;
      if (call_rdy_o !== e_rdy) begin
        errors++; $display("[TB] FAIL call_rdy: got %b want %b at %0t", call_rdy_o, e_rdy, $time);
      end
      checks++;
      if (ret_pop_o !== e_pop) begin
        errors++; $display("[TB] FAIL ret_pop: got %b want %b at %0t", ret_pop_o, e_pop, $time);
      end
      checks++;
      if (ret_vld_o !== (hold.size() != 0)) begin
        errors++; $display("[TB] FAIL ret_vld: got %b want %b at %0t", ret_vld_o, hold.size() != 0, $time);
      end
      if (hold.size() != 0) begin
        checks++;
        if ({ret_child_o, ret_data_o} !== hold[0]) begin
          errors++; $display("[TB] FAIL ret_word: got %h want %h at %0t", {ret_child_o, ret_data_o}, hold[0], $time);
        end
      end
      checks++;
      if (outstanding_o !== m_out[OUT_W-1:0]) begin
        errors++; $display("[TB] FAIL outstanding: got %0d want %0d at %0t", outstanding_o, m_out, $time);
      end
      checks++;
      if (busy_o !== ((pend.size() != 0) || (m_out != 0) || (hold.size() != 0))) begin
        errors++; $display("[TB] FAIL busy: got %b at %0t", busy_o, $time);
      end
      checks++;
      if (err_o !== m_err) begin
        errors++; $display("[TB] FAIL err: got %b want %b at %0t", err_o, m_err, $time);
      end
    end else begin
      e_write = 0; e_rdy = 0; e_acc = 0; e_hs = 0; e_pop = 0;
    end
  end

  // model state update at the clock edge, then present the FIFO head
  always @(posedge clk) begin
    if (!rstn) begin
      pend.delete();
      hold.delete();
      m_out = 0;
      m_err = 0;
    end else begin
      if (e_write) void'(pend.pop_front());
      if (e_acc) begin
        pend.push_back({call_pc_i, call_ret_i, call_child_i, call_args_i});
        if (call_ret_i) m_acc_ret++;
      end
      if (e_hs && (m_out == 0)) m_err = 1;
      if (e_acc && call_ret_i && !e_hs) m_out++;
      else if (e_hs && !(e_acc && call_ret_i) && (m_out > 0)) m_out--;
      if (e_hs) void'(hold.pop_front());
      if (e_pop && (ret_src.size() != 0)) hold.push_back(ret_src.pop_front());
    end
    #1;
    ret_empty_n_i = (ret_src.size() != 0);
    ret_fifo_i    = (ret_src.size() != 0) ? ret_src[0] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic send_call(input logic [LC-1:0] ch, input logic r,
                           input logic [31:0] pc, input logic [127:0] a);
    int n = 0;
    call_vld_i = 1; call_child_i = ch; call_ret_i = r; call_pc_i = pc; call_args_i = a;
    @(negedge clk);
    while (!call_rdy_o && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (call_rdy_o !== 1'b1) begin
      errors++; $display("[TB] FAIL send_call_timeout: rdy %b want 1", call_rdy_o);
    end
    tick();
    call_vld_i = 0;
  endtask

  task automatic wait_ret_vld();
    int n = 0;
    @(negedge clk);
    while (!ret_vld_o && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (ret_vld_o !== 1'b1) begin
      errors++; $display("[TB] FAIL ret_vld_timeout: vld %b want 1", ret_vld_o);
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (3) tick();
    checks++;
    if ({cmd_write_o, cmd_din_o, ret_vld_o, ret_child_o, ret_data_o, outstanding_o, busy_o, err_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h want 0",
        {cmd_write_o, cmd_din_o, ret_vld_o, ret_child_o, ret_data_o, outstanding_o, busy_o, err_o});
    end
    rstn = 1;
    tick();
  endtask

  task automatic test_single_call();
    logic [127:0] a = {16{8'h11}};
    send_call(6'd5, 1'b1, 32'h0000_1000, a);
    sample();
    checks++;
    if (cmd_write_o !== 1'b1) begin errors++; $display("[TB] FAIL single_write: got %b want 1", cmd_write_o); end
    checks++;
    if (cmd_din_o[127:0] !== a) begin errors++; $display("[TB] FAIL single_args: got %h want %h", cmd_din_o[127:0], a); end
    checks++;
    if (cmd_din_o[133:128] !== 6'd5) begin errors++; $display("[TB] FAIL single_child: got %0d want 5", cmd_din_o[133:128]); end
    checks++;
    if (cmd_din_o[134] !== 1'b1) begin errors++; $display("[TB] FAIL single_retreq: got %b want 1", cmd_din_o[134]); end
    checks++;
    if (cmd_din_o[166:135] !== 32'h0000_1000) begin errors++; $display("[TB] FAIL single_pc: got %h want 1000", cmd_din_o[166:135]); end
    checks++;
    if (outstanding_o !== 2'd1) begin errors++; $display("[TB] FAIL single_outstanding: got %0d want 1", outstanding_o); end
    tick();
    ret_src.push_back({6'd5, 32'h1234_5678});
    ret_rdy_i = 1;
    repeat (5) tick();
    ret_rdy_i = 0;
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("[TB] FAIL single_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_full_n();
    int w0;
    cmd_full_n_i = 0;
    w0 = wr_count;
    send_call(6'd1, 1'b0, 32'hA, {4{32'hAAAA_0001}});
    call_vld_i = 1; call_child_i = 6'd2; call_ret_i = 0; call_pc_i = 32'hB; call_args_i = {4{32'hBBBB_0002}};
    repeat (4) begin
      sample();
      checks++;
      if (cmd_write_o !== 1'b0) begin errors++; $display("[TB] FAIL fulln_write: got %b want 0", cmd_write_o); end
      checks++;
      if (cmd_din_o !== {32'hA, 1'b0, 6'd1, {4{32'hAAAA_0001}}}) begin
        errors++; $display("[TB] FAIL fulln_din_stable: got %h", cmd_din_o);
      end
      tick();
    end
    cmd_full_n_i = 1;
    send_call(6'd2, 1'b0, 32'hB, {4{32'hBBBB_0002}});
    send_call(6'd3, 1'b0, 32'hC, {4{32'hCCCC_0003}});
    repeat (3) tick();
    checks++;
    if (wr_count - w0 !== 3) begin errors++; $display("[TB] FAIL fulln_writes: got %0d want 3", wr_count - w0); end
  endtask

  task automatic test_credit_limit();
    send_call(6'd2, 1'b1, 32'h20, 128'h2);
    send_call(6'd3, 1'b1, 32'h30, 128'h3);
    call_vld_i = 1; call_child_i = 6'd4; call_ret_i = 1; call_pc_i = 32'h40; call_args_i = 128'h4;
    repeat (3) begin
      sample();
      checks++;
      if (call_rdy_o !== 1'b0) begin errors++; $display("[TB] FAIL limit_stall: got %b want 0", call_rdy_o); end
      checks++;
      if (outstanding_o !== 2'd2) begin errors++; $display("[TB] FAIL limit_count: got %0d want 2", outstanding_o); end
      tick();
    end
    call_ret_i = 0;
    sample();
    checks++;
    if (call_rdy_o !== 1'b1) begin errors++; $display("[TB] FAIL limit_noret_accept: got %b want 1", call_rdy_o); end
    tick();
    call_vld_i = 0;
    ret_src.push_back({6'd2, 32'h0000_2222});
    ret_rdy_i = 1;
    repeat (5) tick();
    ret_rdy_i = 0;
    checks++;
    if (outstanding_o !== 2'd1) begin errors++; $display("[TB] FAIL limit_one_ret: got %0d want 1", outstanding_o); end
  endtask

  task automatic test_ret_hold();
    int p0 = pop_count;
    ret_rdy_i = 0;
    ret_src.push_back({6'd9, 32'hDEAD_BEEF});
    wait_ret_vld();
    repeat (3) begin
      sample();
      checks++;
      if ({ret_vld_o, ret_child_o, ret_data_o} !== {1'b1, 6'd9, 32'hDEAD_BEEF}) begin
        errors++; $display("[TB] FAIL hold_word: got %b %0d %h want 1 9 deadbeef", ret_vld_o, ret_child_o, ret_data_o);
      end
      checks++;
      if (outstanding_o !== 2'd1) begin errors++; $display("[TB] FAIL hold_count: got %0d want 1", outstanding_o); end
      tick();
    end
    checks++;
    if (pop_count - p0 !== 1) begin errors++; $display("[TB] FAIL hold_pops: got %0d want 1", pop_count - p0); end
    ret_rdy_i = 1;
    tick();
    ret_rdy_i = 0;
    sample();
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("[TB] FAIL hold_release: got %0d want 0", outstanding_o); end
    tick();
  endtask

  task automatic test_same_cycle();
    send_call(6'd7, 1'b1, 32'h70, 128'h7);
    ret_src.push_back({6'd7, 32'h0000_CAFE});
    wait_ret_vld();
    call_vld_i = 1; call_child_i = 6'd8; call_ret_i = 1; call_pc_i = 32'h80; call_args_i = 128'h8;
    ret_rdy_i = 1;
    sample();
    checks++;
    if (call_rdy_o !== 1'b1) begin errors++; $display("[TB] FAIL same_rdy: got %b want 1", call_rdy_o); end
    tick();
    call_vld_i = 0;
    ret_rdy_i = 0;
    sample();
    checks++;
    if (outstanding_o !== 2'd1) begin errors++; $display("[TB] FAIL same_cycle_count: got %0d want 1", outstanding_o); end
    tick();
    ret_src.push_back({6'd8, 32'h0000_BEEF});
    ret_rdy_i = 1;
    repeat (5) tick();
    ret_rdy_i = 0;
  endtask

  task automatic test_random();
    int pushed = m_acc_ret;
    int n = 0;
    for (int i = 0; i < 300; i++) begin
      cmd_full_n_i = ($urandom_range(0, 3) != 0);
      ret_rdy_i    = ($urandom_range(0, 2) != 0);
      call_vld_i   = $urandom_range(0, 1);
      call_ret_i   = $urandom_range(0, 1);
      call_child_i = 6'($urandom_range(0, 63));
      call_pc_i    = $urandom;
      call_args_i  = {$urandom, $urandom, $urandom, $urandom};
      if ((pushed < m_acc_ret) && ($urandom_range(0, 1) == 1)) begin
        ret_src.push_back({6'($urandom_range(0, 63)), 32'($urandom)});
        pushed++;
      end
      tick();
    end
    call_vld_i = 0;
    cmd_full_n_i = 1;
    ret_rdy_i = 1;
    tick();
    while (pushed < m_acc_ret) begin
      ret_src.push_back({6'd1, 32'h5A5A_0000 + 32'(pushed)});
      pushed++;
    end
    sample();
    while (busy_o && n < 60) begin
      tick();
      sample();
      n++;
    end
    checks++;
    if ({busy_o, outstanding_o, err_o} !== '0) begin
      errors++; $display("[TB] FAIL random_drain: busy %b out %0d err %b want 0 0 0", busy_o, outstanding_o, err_o);
    end
    tick();
    ret_rdy_i = 0;
  endtask

  task automatic test_err_reset();
    ret_src.push_back({6'd3, 32'h0000_0BAD});
    ret_rdy_i = 1;
    repeat (4) tick();
    ret_rdy_i = 0;
    sample();
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b want 1", err_o); end
    repeat (2) tick();
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", err_o); end
    call_vld_i = 1; call_child_i = 6'd1; call_ret_i = 1; call_pc_i = 32'h99; call_args_i = 128'h99;
    tick();
    call_vld_i = 0;
    #1;
    rstn = 0;
    #1;
    checks++;
    if ({cmd_write_o, cmd_din_o, ret_vld_o, ret_child_o, ret_data_o, outstanding_o, busy_o, err_o} !== '0) begin
      errors++; $display("[TB] FAIL midcall_reset: got %h want 0",
        {cmd_write_o, cmd_din_o, ret_vld_o, ret_child_o, ret_data_o, outstanding_o, busy_o, err_o});
    end
    ret_src.delete();
    repeat (2) tick();
    rstn = 1;
    tick();
    sample();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL err_after_reset: got %b want 0", err_o); end
    tick();
  endtask

  initial begin
    rstn = 0;
    call_vld_i = 0; call_child_i = '0; call_ret_i = 0; call_pc_i = '0; call_args_i = '0;
    cmd_full_n_i = 1; ret_empty_n_i = 0; ret_fifo_i = '0; ret_rdy_i = 0;
    test_reset();
    test_single_call();
    test_full_n();
    test_credit_limit();
    test_ret_hold();
    test_same_cycle();
    test_random();
    test_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
